// File: rtl/kf_xy_router.sv
`default_nettype none
// ============================================================================
// Module      : kf_xy_router
// Description : Five-port dimension-ordered (XY) mesh router. Each input
//               port has its own FIFO. The head flit of each FIFO is routed
//               X-first, then Y. Heads addressed outside the mesh are
//               discarded and counted. Each output has one registered stage,
//               fed by a round-robin arbiter.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready/in_flit    - per-port ingress handshake
//               out_valid/out_ready/out_flit - per-port egress handshake
//               drop_count - saturating count of discarded flits
//               busy       - any FIFO or output register occupied
//               Port index: 0=Local 1=North 2=East 3=South 4=West
//               Flit layout: {dest_x, dest_y, neuron_id, payload}, MSB first
// Revision    : 1.0 - initial release
// ============================================================================
module kf_xy_router #(
    parameter int  COORD_BITS   = 8,
    parameter int  NID_BITS     = 8,
    parameter int  PAYLOAD_BITS = 8,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  MESH_X       = 2,
    parameter int  MESH_Y       = 2,
    parameter int  MY_X         = 0,
    parameter int  MY_Y         = 0,
    localparam int FLIT_W       = 2*COORD_BITS + NID_BITS + PAYLOAD_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             in_valid,
    output logic [4:0]             in_ready,
    input  logic [4:0][FLIT_W-1:0] in_flit,
    output logic [4:0]             out_valid,
    input  logic [4:0]             out_ready,
    output logic [4:0][FLIT_W-1:0] out_flit,
    output logic [15:0]            drop_count,
    output logic                   busy
);

    localparam int         c_NUM_PORTS  = 5;
    localparam int         c_AW         = $clog2(FIFO_DEPTH);
    localparam logic [2:0] c_PORT_LOCAL = 3'd0;
    localparam logic [2:0] c_PORT_NORTH = 3'd1;
    localparam logic [2:0] c_PORT_EAST  = 3'd2;
    localparam logic [2:0] c_PORT_SOUTH = 3'd3;
    localparam logic [2:0] c_PORT_WEST  = 3'd4;

    // Coordinates are compared at 32 bits so that a mesh dimension equal to
    // 2**COORD_BITS does not wrap to zero.
    localparam logic [31:0] c_MY_X   = 32'(MY_X);
    localparam logic [31:0] c_MY_Y   = 32'(MY_Y);
    localparam logic [31:0] c_MESH_X = 32'(MESH_X);
    localparam logic [31:0] c_MESH_Y = 32'(MESH_Y);

    // Returns (base + off) mod 5, for base and off both in 0..4.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

    logic [FLIT_W-1:0] w_head      [c_NUM_PORTS];
    logic [2:0]        w_route     [c_NUM_PORTS];
    logic [2:0]        w_grant_idx [c_NUM_PORTS];
    logic [4:0]        w_empty;
    logic [4:0]        w_full;
    logic [4:0]        w_push;
    logic [4:0]        w_pop;
    logic [4:0]        w_drop;
    logic [4:0]        w_req;
    logic [4:0]        w_granted;
    logic [4:0]        w_grant_vld;
    logic [4:0]        w_out_free;
    logic [16:0]       w_drop_sum;
    logic [16:0]       w_drop_next;

    logic [2:0]        r_rr        [c_NUM_PORTS];
    logic [4:0]        r_out_valid;
    logic [FLIT_W-1:0] r_out_flit  [c_NUM_PORTS];
    logic [15:0]       r_drop_count;

    // ------------------------------------------------------------------
    // Input FIFOs and route computation
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NUM_PORTS; gi++) begin : g_in
        logic [FLIT_W-1:0]     r_mem [FIFO_DEPTH];
        logic [c_AW:0]         r_wr_ptr;
        logic [c_AW:0]         r_rd_ptr;
        logic [COORD_BITS-1:0] w_dx;
        logic [COORD_BITS-1:0] w_dy;
        logic [31:0]           w_dx_ext;
        logic [31:0]           w_dy_ext;

        // The extra pointer MSB distinguishes full from empty when the
        // index bits match.
        assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
        assign w_full[gi]  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                             (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
        // Ready is taken from the registered pointers only. A pop in the
        // same cycle does not reopen a full FIFO until the next cycle.
        assign w_push[gi]  = in_valid[gi] & ~w_full[gi];
        assign w_head[gi]  = r_mem[r_rd_ptr[c_AW-1:0]];

        assign w_dx     = w_head[gi][FLIT_W-1 -: COORD_BITS];
        assign w_dy     = w_head[gi][FLIT_W-1-COORD_BITS -: COORD_BITS];
        assign w_dx_ext = 32'(w_dx);
        assign w_dy_ext = 32'(w_dy);

        assign w_drop[gi]  = !w_empty[gi] &&
                             ((w_dx_ext >= c_MESH_X) || (w_dy_ext >= c_MESH_Y));
        assign w_route[gi] = (w_dx_ext > c_MY_X) ? c_PORT_EAST  :
                             (w_dx_ext < c_MY_X) ? c_PORT_WEST  :
                             (w_dy_ext > c_MY_Y) ? c_PORT_NORTH :
                             (w_dy_ext < c_MY_Y) ? c_PORT_SOUTH : c_PORT_LOCAL;
        assign w_req[gi]   = !w_empty[gi] && !w_drop[gi];
        // Out-of-mesh heads leave without arbitration.
        assign w_pop[gi]   = w_drop[gi] | w_granted[gi];

        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= in_flit[gi];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration per output
    // ------------------------------------------------------------------
    // A stage may accept a new flit when it is empty or is being drained
    // this cycle.
    assign w_out_free = ~r_out_valid | out_ready;

    // Each input requests exactly one output (its route), so one input is
    // never granted twice and pops at most once per cycle.
    always_comb begin
        logic [2:0] w_cand;
        w_cand      = '0;
        w_grant_vld = '0;
        w_granted   = '0;
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            w_grant_idx[p] = '0;
            for (int k = 0; k < c_NUM_PORTS; k++) begin
                w_cand = wrap_add(r_rr[p], 3'(k));
                if (!w_grant_vld[p] && w_out_free[p] && w_req[w_cand] &&
                    (w_route[w_cand] == 3'(p))) begin
                    w_grant_vld[p] = 1'b1;
                    w_grant_idx[p] = w_cand;
                end
            end
            if (w_grant_vld[p]) begin
                w_granted[w_grant_idx[p]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers and arbiter pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                r_out_flit[p] <= '0;
                r_rr[p]       <= '0;
            end
        end else begin
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                if (w_grant_vld[p]) begin
                    r_out_valid[p] <= 1'b1;
                    r_out_flit[p]  <= w_head[w_grant_idx[p]];
                    r_rr[p]        <= wrap_add(w_grant_idx[p], 3'd1);
                end else if (out_ready[p]) begin
                    r_out_valid[p] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop counter: several inputs may discard in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < c_NUM_PORTS; i++) begin
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
        end
    end

    assign w_drop_next = 17'(r_drop_count) + w_drop_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop_next > 17'h0FFFF) begin
            r_drop_count <= 16'hFFFF;
        end else begin
            r_drop_count <= w_drop_next[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar go = 0; go < c_NUM_PORTS; go++) begin : g_out
        assign out_flit[go] = r_out_flit[go];
    end

    assign out_valid  = r_out_valid;
    assign in_ready   = ~w_full;
    assign drop_count = r_drop_count;
    assign busy       = (|(~w_empty)) | (|r_out_valid);

endmodule
`default_nettype wire

// File: tb/tb_kf_xy_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_kf_xy_router
// Description : Self-checking bench for kf_xy_router on a 4x4 mesh at node
//               (1,1). A queue-based model tracks every accepted flit per
//               input/output path and checks each egress flit and each
//               held output against it. Directed vectors pin the latency,
//               XY routing, arbitration order, backpressure, drop and
//               reset behaviour with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kf_xy_router;

    localparam int FW = 32;
    typedef logic [FW-1:0] flit_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       in_valid;
    logic [4:0]       in_ready;
    logic [4:0][FW-1:0] in_flit;
    logic [4:0]       out_valid;
    logic [4:0]       out_ready;
    logic [4:0][FW-1:0] out_flit;
    logic [15:0]      drop_count;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    kf_xy_router #(
        .COORD_BITS  (8),
        .NID_BITS    (8),
        .PAYLOAD_BITS(8),
        .FIFO_DEPTH  (4),
        .MESH_X      (4),
        .MESH_Y      (4),
        .MY_X        (1),
        .MY_Y        (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .drop_count(drop_count),
        .busy      (busy)
    );

    function automatic flit_t mk(input int x, input int y, input int n, input int pl);
        return {8'(x), 8'(y), 8'(n), 8'(pl)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: XY routing on a 4x4 mesh at (1,1).
    // Returns output port, or -1 when the flit must be dropped.
    // ------------------------------------------------------------------
    function automatic int route_of(input flit_t f);
        int x, y;
        x = int'(f[31:24]);
        y = int'(f[23:16]);
        if (x >= 4 || y >= 4) return -1;
        if (x > 1) return 2;
        if (x < 1) return 4;
        if (y > 1) return 1;
        if (y < 1) return 3;
        return 0;
    endfunction

    flit_t q [5][5][$];
    int    exp_drops = 0;
    bit    held      [5];
    flit_t held_flit [5];

    // Inputs only change just after a rising edge, so the values seen at
    // the falling edge are exactly those the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                held[i] = 1'b0;
                for (int p = 0; p < 5; p++) q[i][p].delete();
            end
            exp_drops = 0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (held[p]) begin
                    chk($sformatf("hold_valid[%0d]", p), 64'(out_valid[p]), 64'd1);
                    chk($sformatf("hold_flit[%0d]", p), 64'(out_flit[p]), 64'(held_flit[p]));
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    bit found;
                    found = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        if (!found && q[i][p].size() > 0 && q[i][p][0] == out_flit[p]) begin
                            found = 1'b1;
                            void'(q[i][p].pop_front());
                        end
                    end
                    vectors++;
                    if (!found) begin
                        miscompares++;
                        $display("FAIL egress[%0d]: got flit %08h, expected head of a pending path (t=%0t)",
                                 p, out_flit[p], $time);
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    int r;
                    r = route_of(in_flit[i]);
                    if (r < 0) exp_drops++;
                    else q[i][r].push_back(in_flit[i]);
                end
            end
            for (int p = 0; p < 5; p++) begin
                held[p]      = out_valid[p] && !out_ready[p];
                held_flit[p] = out_flit[p];
            end
        end
    end

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < 5; i++)
            for (int p = 0; p < 5; p++) n += q[i][p].size();
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        flit_t exp_f;
        int    acc;
        bit    take;

        rst       = 1'b1;
        in_valid  = '0;
        in_flit   = '0;
        out_ready = '1;
        #1;
        chk("rst_out_valid_immediate", 64'(out_valid), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'h1F);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_out_flit0", 64'(out_flit[0]), 64'd0);

        // Local delivery and minimum latency
        in_valid[0] = 1'b1;
        in_flit[0]  = mk(1, 1, 5, 8'h11);
        tick();                                  // accepted at edge k
        in_valid = '0;
        chk("local_not_yet", 64'(out_valid), 64'd0);
        chk("local_busy", 64'(busy), 64'd1);
        tick();                                  // after edge k+1
        chk("local_valid", 64'(out_valid), 64'b00001);
        chk("local_flit", 64'(out_flit[0]), 64'h01010511);
        tick();
        chk("local_drained", 64'(out_valid), 64'd0);

        // XY ordering: W->E, S->N, N->W, all in one cycle
        in_valid    = 5'b11010;
        in_flit[4]  = mk(3, 0, 1, 8'h21);
        in_flit[3]  = mk(1, 3, 2, 8'h22);
        in_flit[1]  = mk(0, 2, 3, 8'h23);
        tick();
        in_valid = '0;
        tick();
        chk("xy_valid", 64'(out_valid), 64'b10110);
        chk("xy_east", 64'(out_flit[2]), 64'h03000121);
        chk("xy_north", 64'(out_flit[1]), 64'h01030222);
        chk("xy_west", 64'(out_flit[4]), 64'h00020323);
        tick();

        // Contention on East from North, South, West; two rounds
        pulse_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            int base;
            base = (rnd == 0) ? 8'hA0 : 8'hB0;
            in_valid   = 5'b11010;
            in_flit[1] = mk(2, 1, 1, base + 1);
            in_flit[3] = mk(2, 1, 3, base + 3);
            in_flit[4] = mk(2, 1, 4, base + 4);
            tick();
            in_valid = '0;
            for (int k = 0; k < 3; k++) begin
                int src;
                src = (k == 0) ? 1 : (k == 1) ? 3 : 4;
                tick();
                exp_f = mk(2, 1, src, base + src);
                chk($sformatf("rr_valid_r%0d_%0d", rnd, k), 64'(out_valid), 64'b00100);
                chk($sformatf("rr_flit_r%0d_%0d", rnd, k), 64'(out_flit[2]), 64'(exp_f));
            end
            tick();
            chk($sformatf("rr_done_r%0d", rnd), 64'(out_valid), 64'd0);
        end

        // Backpressure on East with six offers from West
        out_ready[2] = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid[4] = (acc < 6);
            in_flit[4]  = mk(2, 1, acc, 8'hC0 + acc);
            @(negedge clk);
            take = in_ready[4] && in_valid[4];
            tick();
            if (take) acc++;
        end
        in_valid = '0;
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_in_ready_low", 64'(in_ready[4]), 64'd0);
        chk("bp_out_held", 64'(out_valid[2]), 64'd1);
        chk("bp_out_first", 64'(out_flit[2]), 64'h020100C0);
        out_ready[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_f = mk(2, 1, j, 8'hC0 + j);
            chk($sformatf("bp_release_valid_%0d", j), 64'(out_valid[2]), 64'd1);
            chk($sformatf("bp_release_flit_%0d", j), 64'(out_flit[2]), 64'(exp_f));
            tick();
            if (j == 0) chk("bp_in_ready_back", 64'(in_ready[4]), 64'd1);
        end
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_busy_idle", 64'(busy), 64'd0);

        // Single out-of-mesh flit
        in_valid[0] = 1'b1;
        in_flit[0]  = mk(4, 0, 9, 8'hDD);
        tick();
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("drop_no_out_%0d", c), 64'(out_valid), 64'd0);
            tick();
        end
        chk("drop_count_one", 64'(drop_count), 64'd1);

        // Saturation: five ports dropping every cycle
        in_valid = '1;
        for (int p = 0; p < 5; p++) in_flit[p] = mk(4, 0, p, 8'hEE);
        repeat (13200) tick();
        in_valid = '0;
        repeat (3) tick();
        chk("drop_count_sat", 64'(drop_count), 64'hFFFF);
        chk("drop_count_model", 64'(drop_count), 64'((exp_drops > 65535) ? 65535 : exp_drops));
        chk("drop_no_out_after", 64'(out_valid), 64'd0);

        // Reset with three flits in flight
        out_ready[2] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid[4] = 1'b1;
            in_flit[4]  = mk(2, 1, j, 8'hF0 + j);
            tick();
        end
        in_valid = '0;
        chk("mid_busy_before", 64'(busy), 64'd1);
        chk("mid_valid_before", 64'(out_valid[2]), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_drop_count", 64'(drop_count), 64'd0);
        tick();
        rst       = 1'b0;
        out_ready = '1;
        chk("mid_in_ready", 64'(in_ready), 64'h1F);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("mid_no_stale_%0d", c), 64'(out_valid), 64'd0);
        end

        repeat (3) tick();
        chk("final_pending", 64'(pending()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
